// File: rtl/lfsr_gen.sv
// Parametrised LFSR generator (Fibonacci or Galois) with seed load, zero-seed
// protection and measurement of the sequence period back to the active seed.
module lfsr_gen #(
  parameter int               WIDTH  = 4,
  parameter logic [WIDTH-1:0] TAPS   = 4'b1100,
  parameter logic [WIDTH-1:0] SEED   = 4'b0001,
  parameter bit               GALOIS = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic [WIDTH-1:0] lfsr_o,
  output logic             bit_o,
  output logic             wrap_o,
  output logic [WIDTH-1:0] period_o,
  output logic             period_vld_o,
  output logic             lockup_o
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] seed_ref_q, seed_ref_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             vld_q, vld_d;
  logic             wrap_q, wrap_d;
  logic             lockup_q, lockup_d;
  logic [WIDTH-1:0] step_d;

  always_comb begin
    step_d = '0;
    if (GALOIS) begin
      step_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    end else begin
      step_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
    end
  end

  always_comb begin
    lfsr_d     = lfsr_q;
    seed_ref_d = seed_ref_q;
    cnt_d      = cnt_q;
    period_d   = period_q;
    vld_d      = vld_q;
    wrap_d     = 1'b0;
    lockup_d   = 1'b0;
    if (load_i) begin
      // A zero seed would lock the register up, so fall back to the default.
      if (seed_i != '0) begin
        lfsr_d     = seed_i;
        seed_ref_d = seed_i;
      end else begin
        lfsr_d     = SEED;
        seed_ref_d = SEED;
        lockup_d   = 1'b1;
      end
      cnt_d    = '0;
      period_d = '0;
      vld_d    = 1'b0;
    end else if (en_i) begin
      lfsr_d = step_d;
      if (step_d == seed_ref_q) begin
        wrap_d   = 1'b1;
        period_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + WIDTH'(1);
        vld_d    = 1'b1;
        cnt_d    = '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr_q     <= SEED;
      seed_ref_q <= SEED;
      cnt_q      <= '0;
      period_q   <= '0;
      vld_q      <= 1'b0;
      wrap_q     <= 1'b0;
      lockup_q   <= 1'b0;
    end else begin
      lfsr_q     <= lfsr_d;
      seed_ref_q <= seed_ref_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      vld_q      <= vld_d;
      wrap_q     <= wrap_d;
      lockup_q   <= lockup_d;
    end
  end

  assign lfsr_o       = lfsr_q;
  assign bit_o        = lfsr_q[0];
  assign wrap_o       = wrap_q;
  assign period_o     = period_q;
  assign period_vld_o = vld_q;
  assign lockup_o     = lockup_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: a Fibonacci and a Galois instance driven in
// lockstep from a vector table, plus hand sequences for enable toggling and reset.
module tb_lfsr_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en_i = 1'b0;
  logic       load_i = 1'b0;
  logic [3:0] seed_i = 4'h0;

  logic [3:0] f_lfsr, g_lfsr, f_per, g_per;
  logic       f_bit, g_bit, f_wrap, g_wrap, f_vld, g_vld, f_lock, g_lock;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .SEED(4'b0001), .GALOIS(1'b0)) u_fib (
    .clk(clk), .reset(reset), .en_i(en_i), .load_i(load_i), .seed_i(seed_i),
    .lfsr_o(f_lfsr), .bit_o(f_bit), .wrap_o(f_wrap), .period_o(f_per),
    .period_vld_o(f_vld), .lockup_o(f_lock)
  );

  lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .SEED(4'b0001), .GALOIS(1'b1)) u_gal (
    .clk(clk), .reset(reset), .en_i(en_i), .load_i(load_i), .seed_i(seed_i),
    .lfsr_o(g_lfsr), .bit_o(g_bit), .wrap_o(g_wrap), .period_o(g_per),
    .period_vld_o(g_vld), .lockup_o(g_lock)
  );

  typedef struct {
    logic       rst_n;
    logic       en;
    logic       load;
    logic [3:0] seed;
    logic [3:0] ef;
    logic [3:0] eg;
    logic       ew;
    logic [3:0] ep;
    logic       ev;
    logic       el;
  } vec_t;

  vec_t       tbl [0:63];
  int         n_vec = 0;
  logic [3:0] fib_seq [0:14];
  logic [3:0] gal_seq [0:14];

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic rst_n, input logic en, input logic load, input logic [3:0] seed);
    @(negedge clk);
    reset  = rst_n;
    en_i   = en;
    load_i = load;
    seed_i = seed;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input logic [3:0] ef, input logic [3:0] eg, input logic ew,
                       input logic [3:0] ep, input logic ev, input logic el);
    cmp("fib_lfsr", f_lfsr, ef);
    cmp("gal_lfsr", g_lfsr, eg);
    cmp("fib_bit", {3'b0, f_bit}, {3'b0, ef[0]});
    cmp("gal_bit", {3'b0, g_bit}, {3'b0, eg[0]});
    cmp("fib_wrap", {3'b0, f_wrap}, {3'b0, ew});
    cmp("gal_wrap", {3'b0, g_wrap}, {3'b0, ew});
    cmp("fib_period", f_per, ep);
    cmp("gal_period", g_per, ep);
    cmp("fib_vld", {3'b0, f_vld}, {3'b0, ev});
    cmp("gal_vld", {3'b0, g_vld}, {3'b0, ev});
    cmp("fib_lockup", {3'b0, f_lock}, {3'b0, el});
    cmp("gal_lockup", {3'b0, g_lock}, {3'b0, el});
  endtask

  function automatic void add(input logic rst_n, input logic en, input logic load,
                              input logic [3:0] seed, input logic [3:0] ef, input logic [3:0] eg,
                              input logic ew, input logic [3:0] ep, input logic ev, input logic el);
    tbl[n_vec] = '{rst_n, en, load, seed, ef, eg, ew, ep, ev, el};
    n_vec++;
  endfunction

  initial begin
    int fi, gi, wraps;

    fib_seq = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
    gal_seq = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE,
                4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2};

    // reset, then a full period from the default seed
    add(0, 0, 0, 4'h0, 4'h1, 4'h1, 0, 4'h0, 0, 0);
    for (int k = 1; k <= 15; k++)
      add(1, 1, 0, 4'h0, fib_seq[k % 15], gal_seq[k % 15],
          (k == 15), (k == 15) ? 4'hF : 4'h0, (k == 15), 0);
    add(1, 1, 0, 4'h0, 4'h2, 4'hC, 0, 4'hF, 1, 0);
    add(1, 0, 0, 4'h0, 4'h2, 4'hC, 0, 4'hF, 1, 0);
    // zero seed rejected, even with en_i high
    add(1, 1, 1, 4'h0, 4'h1, 4'h1, 0, 4'h0, 0, 1);
    add(1, 0, 0, 4'h0, 4'h1, 4'h1, 0, 4'h0, 0, 0);
    // seed 9 with en_i in the same cycle: load wins, then a full period
    add(1, 1, 1, 4'h9, 4'h9, 4'h9, 0, 4'h0, 0, 0);
    for (int k = 1; k <= 15; k++)
      add(1, 1, 0, 4'h0, fib_seq[(3 + k) % 15], gal_seq[(11 + k) % 15],
          (k == 15), (k == 15) ? 4'hF : 4'h0, (k == 15), 0);

    for (int i = 0; i < n_vec; i++) begin
      apply(tbl[i].rst_n, tbl[i].en, tbl[i].load, tbl[i].seed);
      check(tbl[i].ef, tbl[i].eg, tbl[i].ew, tbl[i].ep, tbl[i].ev, tbl[i].el);
    end

    // en_i toggling: 15 steps spread over 30 cycles, no pulse on hold cycles
    apply(0, 0, 0, 4'h0);
    check(4'h1, 4'h1, 0, 4'h0, 0, 0);
    fi = 0;
    wraps = 0;
    for (int i = 0; i < 30; i++) begin
      apply(1, (i % 2 == 1), 0, 4'h0);
      if (i % 2 == 1) fi++;
      if (f_wrap) wraps++;
      check(fib_seq[fi % 15], gal_seq[fi % 15], (i == 29),
            (i == 29) ? 4'hF : 4'h0, (i == 29), 0);
    end
    cmp("toggle_wrap_count", 4'(wraps), 4'h1);

    // reset at step 7 of a sequence that already holds a valid period
    for (int k = 1; k <= 7; k++) begin
      apply(1, 1, 0, 4'h0);
      check(fib_seq[k], gal_seq[k], 0, 4'hF, 1, 0);
    end
    apply(0, 1, 0, 4'h0);
    check(4'h1, 4'h1, 0, 4'h0, 0, 0);
    gi = 1;
    apply(1, 1, 0, 4'h0);
    check(fib_seq[gi], gal_seq[gi], 0, 4'h0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
